ab_input_cond: RTL
==================

AB_INPUT_COND -- requirements
Module: ab_input_cond

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive synchronized samples needed to accept a new input level; legal range 1..255.
REQ-002 The block SHALL have parameter PULSE_MODE, default 1: 1 makes each output a one-cycle pulse on an accepted rising edge; 0 makes each output follow its debounced level.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port a_raw, input, 1 bit: asynchronous, bouncy raw A source.
REQ-006 The block SHALL have port b_raw, input, 1 bit: asynchronous, bouncy raw B source.
REQ-007 The block SHALL have port A, output, 1 bit: conditioned A, driving the downstream A/B-to-N/R FSM.
REQ-008 The block SHALL have port B, output, 1 bit: conditioned B, driving the downstream FSM.
REQ-009 The block SHALL have port a_level, output, 1 bit: debounced level of a_raw.
REQ-010 The block SHALL have port b_level, output, 1 bit: debounced level of b_raw.

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer; s denotes the second flop output.
REQ-012 Each channel SHALL run its own FSM with states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
- STABLE_LO→WAIT_HI on s=1.
- STABLE_HI→WAIT_LO on s=0.
REQ-013 In WAIT_HI or WAIT_LO, the counter SHALL advance once per edge while s differs from the level.
- s returns to the level before the count completes → back to the STABLE state, counter 0, no output change.
REQ-014 On the edge where DEBOUNCE_CYCLES consecutive differing samples of s are reached, the level SHALL flip and the FSM SHALL enter the opposite STABLE state with counter 0.
REQ-015 Latency: if raw is stable from before edge t, the level SHALL change at edge t+1+DEBOUNCE_CYCLES.
- Example: DEBOUNCE_CYCLES=4, t=10 → edge 15.
REQ-016 With PULSE_MODE=1, A/B SHALL be registered, high for exactly the one cycle following the edge where the level rises, and never asserted on a falling edge.
REQ-017 With PULSE_MODE=0, A SHALL equal a_level and B SHALL equal b_level.
REQ-018 The channels SHALL be fully independent; simultaneous acceptance SHALL assert A and B in the same cycle.
REQ-019 A raw glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no level or output change.
REQ-020 DEBOUNCE_CYCLES=1 SHALL flip the level on the first edge at which s differs from it.
REQ-021 The counter SHALL be 8 bits and SHALL never wrap; it saturates by state exit.

Reset
REQ-022 While rst=1 at a clock edge, all flops SHALL clear: synchronizers, FSMs to STABLE_LO, counters 0, a_level/b_level/A/B 0.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; no pulse is emitted for it.
REQ-024 If raw is high through reset, the level SHALL rise at edge r+1+DEBOUNCE_CYCLES, where r is the first non-reset edge, and one pulse is emitted.

Structure
REQ-025 The FSM state encodings and the default DEBOUNCE_CYCLES constant SHALL live in shared package ab_cond_pkg.
REQ-026 One channel (synchronizer, FSM, counter, pulse register) SHALL be sub-module ab_debounce_ch, instantiated twice.

Verification
REQ-027 (DEBOUNCE_CYCLES=4, PULSE_MODE=1) For each scenario below, the bench SHALL apply the stimulus and check the required response.
- a_raw 0→1 before edge 10, held → a_level=1 at edge 15; A high for one cycle only.
- a_raw high for 3 cycles then low → a_level and A stay 0 throughout.
- a_raw and b_raw both rise before edge 20 → A and B pulse in the same cycle after edge 25.
- a_level=1, a_raw falls and is held → a_level=0 after 5 edges; A stays 0.
- rst asserted 2 cycles into WAIT_HI, a_raw held high → all outputs 0 during reset; a_level rises at r+5, one pulse.
- PULSE_MODE=0, b_raw bounces 1,0,1 then holds 1 → B equals b_level, rising exactly once.

Source files
------------

// File: rtl/ab_cond_pkg.sv
// Shared types and constants for the A/B input conditioner.
// Debounce FSM encoding, counter width and default filter length.
package ab_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/ab_debounce_ch.sv
// One conditioning channel: 2-flop synchronizer, debounce FSM,
// saturating-by-exit counter and rising-edge pulse register.
module ab_debounce_ch
  import ab_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned PULSE_MODE      = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic out_o
);

  localparam logic [CNT_W-1:0] DB_W = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             s_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             differ;
  logic             hit;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
    end
  end

  assign differ  = s_q ^ level_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign hit     = differ && (cnt_inc == DB_W);

  // Next-state: count differing samples, flip level when the run completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    unique case (state_q)
      STABLE_LO, WAIT_HI: begin
        if (hit) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
        end else if (differ) begin
          state_d = WAIT_HI;
          cnt_d   = cnt_inc;
        end else begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      end
      STABLE_HI, WAIT_LO: begin
        if (hit) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else if (differ) begin
          state_d = WAIT_LO;
          cnt_d   = cnt_inc;
        end else begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    if (PULSE_MODE != 0) begin
      pulse_d = level_d & ~level_q;
    end
  end

  // Debounce state, counter, level and pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign out_o   = (PULSE_MODE != 0) ? pulse_q : level_q;

endmodule

// File: rtl/ab_input_cond.sv
// Conditions two raw bouncy inputs into clean A/B strobes or levels
// for the downstream A/B-to-N/R FSM; channels are independent.
module ab_input_cond
  import ab_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned PULSE_MODE      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic a_level,
  output logic b_level
);

  ab_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .PULSE_MODE     (PULSE_MODE)
  ) u_ch_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .raw_i  (a_raw),
    .level_o(a_level),
    .out_o  (A)
  );

  ab_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .PULSE_MODE     (PULSE_MODE)
  ) u_ch_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .raw_i  (b_raw),
    .level_o(b_level),
    .out_o  (B)
  );

endmodule
